// File: rtl/frame_sequencer_if.sv
// Register-write / status-read strobes into the frame sequencer and the
// quarter/half-frame enables, IRQ and step index coming back out.
interface frame_sequencer_if;
  logic [7:0] reg_4017;
  logic       reg_event;
  logic       status_read;
  logic       enable_240hz;
  logic       enable_120hz;
  logic       frame_irq;
  logic [2:0] step;

  // CPU / bus side
  modport master (
    output reg_4017,
    output reg_event,
    output status_read,
    input  enable_240hz,
    input  enable_120hz,
    input  frame_irq,
    input  step
  );

  // Sequencer side
  modport slave (
    input  reg_4017,
    input  reg_event,
    input  status_read,
    output enable_240hz,
    output enable_120hz,
    output frame_irq,
    output step
  );
endinterface

// File: rtl/frame_sequencer.sv
// APU $4017 frame counter: divides the CPU clock into quarter/half-frame enables,
// runs the 4-step / 5-step sequences and raises the frame IRQ.
module frame_sequencer #(
  parameter int unsigned STEP_CYCLES = 7457
) (
  input logic               clk,
  input logic               reset,
  frame_sequencer_if.slave  bus
);

  localparam logic [15:0] DivReload = 16'(STEP_CYCLES - 1);

  localparam logic [2:0] Step0 = 3'd0;
  localparam logic [2:0] Step1 = 3'd1;
  localparam logic [2:0] Step2 = 3'd2;
  localparam logic [2:0] Step3 = 3'd3;
  localparam logic [2:0] Step4 = 3'd4;

  logic [15:0] div_q, div_d;
  logic [2:0]  step_q, step_d;
  logic        mode_q, mode_d;
  logic        inhibit_q, inhibit_d;
  logic        quarter_q, quarter_d;
  logic        half_q, half_d;
  logic        irq_q, irq_d;
  logic        tick;
  logic        irq_set;
  logic        irq_clear;

  logic unused_reg_bits;
  assign unused_reg_bits = ^bus.reg_4017[5:0];

  assign tick = (div_q == 16'd0);

  always_comb begin
    div_d     = tick ? DivReload : div_q - 16'd1;
    step_d    = step_q;
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    quarter_d = 1'b0;
    half_d    = 1'b0;
    irq_set   = 1'b0;

    if (bus.reg_event) begin
      // A write restarts the sequence and overrides a coincident tick.
      mode_d    = bus.reg_4017[7];
      inhibit_d = bus.reg_4017[6];
      div_d     = DivReload;
      step_d    = Step0;
      quarter_d = bus.reg_4017[7];
      half_d    = bus.reg_4017[7];
    end else if (tick) begin
      case (step_q)
        Step0: begin
          quarter_d = 1'b1;
          step_d    = Step1;
        end
        Step1: begin
          quarter_d = 1'b1;
          half_d    = 1'b1;
          step_d    = Step2;
        end
        Step2: begin
          quarter_d = 1'b1;
          step_d    = Step3;
        end
        Step3: begin
          if (mode_q) begin
            step_d = Step4;
          end else begin
            quarter_d = 1'b1;
            half_d    = 1'b1;
            irq_set   = ~inhibit_q;
            step_d    = Step0;
          end
        end
        Step4: begin
          quarter_d = 1'b1;
          half_d    = 1'b1;
          step_d    = Step0;
        end
        default: step_d = Step0;
      endcase
    end
  end

  // A set in the same cycle as an acknowledge leaves the flag high.
  assign irq_clear = bus.status_read | (bus.reg_event & bus.reg_4017[6]);

  always_comb begin
    irq_d = irq_q;
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (irq_clear) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= DivReload;
      step_q    <= Step0;
      mode_q    <= 1'b0;
      inhibit_q <= 1'b0;
      quarter_q <= 1'b0;
      half_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      quarter_q <= quarter_d;
      half_q    <= half_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.enable_240hz = quarter_q;
  assign bus.enable_120hz = half_q;
  assign bus.frame_irq    = irq_q;
  assign bus.step         = step_q;

  half_implies_quarter: assert property (@(posedge clk) disable iff (!reset)
    half_q |-> quarter_q);

  step_in_range: assert property (@(posedge clk) disable iff (!reset)
    (mode_q ? (step_q <= Step4) : (step_q <= Step3)));

endmodule
